// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and the CPU / device side.
//
// Handshake: the controller raises interrupt_r (or NON_maskable_interrupt)
// as a level request and holds int_vector stable while it is high. The CPU
// accepts by driving INA high; the request falls on the clock edge that
// samples INA high. INA seen when no request is up is ignored. Service ends
// with a single-cycle eoi strobe, honoured only while in_service is high.
interface interrupt_controller_if;
  logic [7:0] irq_in;
  logic       nmi_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       CPU_busy;
  logic       INA;
  logic       eoi;
  logic       interrupt_r;
  logic       NON_maskable_interrupt;
  logic [2:0] int_vector;
  logic [7:0] pending;
  logic       in_service;

  // Device/CPU side
  modport master (
    output irq_in, nmi_in, mask_we, mask_wdata, CPU_busy, INA, eoi,
    input  interrupt_r, NON_maskable_interrupt, int_vector, pending, in_service
  );

  // Controller side
  modport slave (
    input  irq_in, nmi_in, mask_we, mask_wdata, CPU_busy, INA, eoi,
    output interrupt_r, NON_maskable_interrupt, int_vector, pending, in_service
  );
endinterface

// File: rtl/interrupt_controller.sv
// Eight-source prioritised interrupt controller with one non-maskable input.
// Sources are rising-edge detected into a pending register; the lowest
// enabled pending index is requested. An NMI pre-empts a maskable service
// one level deep and the interrupted service resumes on the NMI's eoi.
module interrupt_controller #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  interrupt_controller_if.slave bus,
  output logic [2:0]            state_dbg,
  output logic [7:0]            mask_dbg
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    REQ         = 3'd1,
    SERVICE     = 3'd2,
    NMI_REQ     = 3'd3,
    NMI_SERVICE = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] pending_q, pending_d;
  logic       nmi_pending_q, nmi_pending_d;
  logic       suspended_q, suspended_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] mask_q;
  logic [7:0] irq_hist;
  logic       nmi_hist;
  logic       hist_valid;
  logic [7:0] irq_rise;
  logic       nmi_rise;
  logic [7:0] enabled;
  logic [2:0] lowest;

  // Edges only count once the history has been loaded after reset, so that
  // levels already high at release are not mistaken for new requests.
  assign irq_rise = hist_valid ? (bus.irq_in & ~irq_hist) : 8'h00;
  assign nmi_rise = hist_valid & bus.nmi_in & ~nmi_hist;
  assign enabled  = pending_q & mask_q;

  // Lowest enabled index wins (bit 0 is highest priority).
  always_comb begin
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (enabled[i]) lowest = 3'(i);
    end
  end

  // Input history for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_hist   <= 8'h00;
      nmi_hist   <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      irq_hist   <= bus.irq_in;
      nmi_hist   <= bus.nmi_in;
      hist_valid <= 1'b1;
    end
  end

  // Mask register; all sources enabled out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) mask_q <= 8'hFF;
    else if (bus.mask_we) mask_q <= bus.mask_wdata;
  end

  // FSM state and the bookkeeping registers it owns.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pending_q     <= 8'h00;
      nmi_pending_q <= 1'b0;
      suspended_q   <= 1'b0;
      vec_q         <= 3'd0;
      wait_q        <= 8'h00;
    end else begin
      state         <= state_next;
      pending_q     <= pending_d;
      nmi_pending_q <= nmi_pending_d;
      suspended_q   <= suspended_d;
      vec_q         <= vec_d;
      wait_q        <= wait_d;
    end
  end

  // Next state; new edges are ORed in last so a set beats a same-edge clear.
  always_comb begin
    state_next    = state;
    pending_d     = pending_q;
    nmi_pending_d = nmi_pending_q;
    suspended_d   = suspended_q;
    vec_d         = vec_q;
    wait_d        = wait_q;
    case (state)
      IDLE: begin
        if (nmi_pending_q) begin
          state_next = NMI_REQ;
        end else if ((|enabled) && !bus.CPU_busy) begin
          state_next = REQ;
          vec_d      = lowest;
          wait_d     = 8'h00;
        end
      end
      REQ: begin
        if (bus.INA) begin
          state_next       = SERVICE;
          pending_d[vec_q] = 1'b0;
        end else if (nmi_pending_q) begin
          state_next = NMI_REQ;
        end else if (wait_q == TIMEOUT_LAST) begin
          state_next = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      SERVICE: begin
        if (bus.eoi) begin
          state_next = IDLE;
        end else if (nmi_pending_q) begin
          state_next  = NMI_REQ;
          suspended_d = 1'b1;
        end
      end
      NMI_REQ: begin
        if (bus.INA) begin
          state_next    = NMI_SERVICE;
          nmi_pending_d = 1'b0;
        end
      end
      NMI_SERVICE: begin
        if (bus.eoi) begin
          if (suspended_q) begin
            state_next  = SERVICE;
            suspended_d = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    pending_d     = pending_d | irq_rise;
    nmi_pending_d = nmi_pending_d | nmi_rise;
  end

  assign bus.interrupt_r            = (state == REQ);
  assign bus.NON_maskable_interrupt = (state == NMI_REQ);
  assign bus.in_service             = (state == SERVICE) || (state == NMI_SERVICE);
  assign bus.int_vector             = vec_q;
  assign bus.pending                = pending_q;
  assign state_dbg                  = state;
  assign mask_dbg                   = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios with literal
// expectations plus a long randomized run, all checked every cycle against a
// behavioural model of the controller's rules.
module tb_interrupt_controller;

  localparam int ACK_TIMEOUT = 16;
  localparam int M_IDLE = 0, M_REQ = 1, M_SRV = 2, M_NREQ = 3, M_NSRV = 4;

  logic       clock;
  logic       reset_n;
  logic [2:0] state_dbg;
  logic [7:0] mask_dbg;
  interrupt_controller_if bus();

  interrupt_controller #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg),
    .mask_dbg  (mask_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  int         m_mode;
  logic [7:0] m_pend;
  logic       m_nmi_pend;
  logic       m_susp;
  logic [7:0] m_mask;
  int         m_vec;
  int         m_waited;
  logic [7:0] m_prev_irq;
  logic       m_prev_nmi;
  logic       m_armed;

  function automatic int lowest_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= M_IDLE; m_pend <= 8'h00; m_nmi_pend <= 1'b0; m_susp <= 1'b0;
      m_mask <= 8'hFF; m_vec <= 0; m_waited <= 0;
      m_prev_irq <= 8'h00; m_prev_nmi <= 1'b0; m_armed <= 1'b0;
    end else begin : step
      logic [7:0] rise;
      logic       nrise;
      int         mode_n, vec_n, waited_n;
      logic [7:0] pend_n;
      logic       nmi_n, susp_n;
      rise     = m_armed ? (bus.irq_in & ~m_prev_irq) : 8'h00;
      nrise    = m_armed && bus.nmi_in && !m_prev_nmi;
      mode_n   = m_mode; vec_n = m_vec; waited_n = m_waited;
      pend_n   = m_pend; nmi_n = m_nmi_pend; susp_n = m_susp;
      if (m_mode == M_IDLE) begin
        if (m_nmi_pend) mode_n = M_NREQ;
        else if ((m_pend & m_mask) != 8'h00 && !bus.CPU_busy) begin
          mode_n = M_REQ; vec_n = lowest_set(m_pend & m_mask); waited_n = 0;
        end
      end else if (m_mode == M_REQ) begin
        if (bus.INA) begin mode_n = M_SRV; pend_n[m_vec] = 1'b0; end
        else if (m_nmi_pend) mode_n = M_NREQ;
        else if (m_waited + 1 >= ACK_TIMEOUT) mode_n = M_IDLE;
        else waited_n = m_waited + 1;
      end else if (m_mode == M_SRV) begin
        if (bus.eoi) mode_n = M_IDLE;
        else if (m_nmi_pend) begin mode_n = M_NREQ; susp_n = 1'b1; end
      end else if (m_mode == M_NREQ) begin
        if (bus.INA) begin mode_n = M_NSRV; nmi_n = 1'b0; end
      end else begin
        if (bus.eoi) begin
          mode_n = m_susp ? M_SRV : M_IDLE;
          susp_n = 1'b0;
        end
      end
      m_mode     <= mode_n;
      m_vec      <= vec_n;
      m_waited   <= waited_n;
      m_pend     <= pend_n | rise;
      m_nmi_pend <= nmi_n | nrise;
      m_susp     <= susp_n;
      if (bus.mask_we) m_mask <= bus.mask_wdata;
      m_prev_irq <= bus.irq_in;
      m_prev_nmi <= bus.nmi_in;
      m_armed    <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("m_irq",     8'(bus.interrupt_r),            8'(m_mode == M_REQ));
      chk("m_nmi",     8'(bus.NON_maskable_interrupt), 8'(m_mode == M_NREQ));
      chk("m_insvc",   8'(bus.in_service),             8'(m_mode == M_SRV || m_mode == M_NSRV));
      chk("m_vector",  8'(bus.int_vector),             8'(m_vec));
      chk("m_pending", bus.pending,                    m_pend);
      chk("m_mask",    mask_dbg,                       m_mask);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.irq_in = 8'h00; bus.nmi_in = 1'b0; bus.mask_we = 1'b0; bus.mask_wdata = 8'h00;
    bus.CPU_busy = 1'b0; bus.INA = 1'b0; bus.eoi = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic ack();
    bus.INA = 1'b1; tick(1); bus.INA = 1'b0;
  endtask

  task automatic end_irq();
    bus.eoi = 1'b1; tick(1); bus.eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.mask_we = 1'b1; bus.mask_wdata = m; tick(1); bus.mask_we = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [7:0] tog;
    reset_n = 1'b0;
    do_reset();
    cmp_en = 1;

    // Reset state
    chk("rst_irq", 8'(bus.interrupt_r), 8'h00);
    chk("rst_nmi", 8'(bus.NON_maskable_interrupt), 8'h00);
    chk("rst_pending", bus.pending, 8'h00);
    chk("rst_mask", mask_dbg, 8'hFF);

    // Single request on source 3
    bus.irq_in = 8'h08; tick(1);
    chk("s1_pending", bus.pending, 8'h08);
    chk("s1_irq_early", 8'(bus.interrupt_r), 8'h00);
    tick(1);
    chk("s1_irq", 8'(bus.interrupt_r), 8'h01);
    chk("s1_vec", 8'(bus.int_vector), 8'h03);
    ack();
    chk("s1_irq_drop", 8'(bus.interrupt_r), 8'h00);
    chk("s1_insvc", 8'(bus.in_service), 8'h01);
    chk("s1_pend_clr", bus.pending, 8'h00);
    end_irq();
    chk("s1_insvc_end", 8'(bus.in_service), 8'h00);
    bus.irq_in = 8'h00; tick(2);

    // Priority and mask: source 2 masked, source 5 served first
    write_mask(8'hFB);
    bus.irq_in = 8'h24; tick(2);
    chk("s2_vec5", 8'(bus.int_vector), 8'h05);
    ack();
    chk("s2_retained", bus.pending, 8'h04);
    write_mask(8'hFF);
    end_irq();
    tick(1);
    chk("s2_irq", 8'(bus.interrupt_r), 8'h01);
    chk("s2_vec2", 8'(bus.int_vector), 8'h02);
    ack(); end_irq();
    bus.irq_in = 8'h00; tick(2);

    // Busy blocks, then timeout after 16 cycles and re-request
    bus.CPU_busy = 1'b1; bus.irq_in = 8'h01; tick(3);
    chk("s3_busy_irq", 8'(bus.interrupt_r), 8'h00);
    bus.CPU_busy = 1'b0; tick(1);
    cnt = 0;
    while (bus.interrupt_r && cnt < 40) begin cnt++; tick(1); end
    chk("s3_req_cycles", 8'(cnt), 8'd16);
    chk("s3_pend0", 8'(bus.pending[0]), 8'h01);
    tick(1);
    chk("s3_rereq", 8'(bus.interrupt_r), 8'h01);
    ack(); end_irq();
    bus.irq_in = 8'h00; tick(2);

    // NMI pre-empts service of source 1 and returns to it
    bus.irq_in = 8'h02; tick(2); ack();
    chk("s4_vec1", 8'(bus.int_vector), 8'h01);
    bus.nmi_in = 1'b1; tick(2);
    chk("s4_nmi", 8'(bus.NON_maskable_interrupt), 8'h01);
    ack();
    chk("s4_nmi_svc", 8'(bus.in_service), 8'h01);
    end_irq();
    chk("s4_resume_vec", 8'(bus.int_vector), 8'h01);
    chk("s4_resume_svc", 8'(bus.in_service), 8'h01);
    end_irq();
    chk("s4_idle", 8'(bus.in_service), 8'h00);
    bus.nmi_in = 1'b0; bus.irq_in = 8'h00; tick(2);

    // Set wins over same-edge clear
    bus.irq_in = 8'h10; tick(2);
    bus.irq_in = 8'h00; tick(1);
    bus.irq_in = 8'h10; bus.INA = 1'b1; tick(1); bus.INA = 1'b0;
    chk("s5_collide", bus.pending, 8'h10);
    end_irq(); tick(1); ack(); end_irq();
    bus.irq_in = 8'h00; tick(2);

    // Reset during a request, with the source level held high
    write_mask(8'h40);
    bus.irq_in = 8'h40; tick(2);
    chk("s6_irq", 8'(bus.interrupt_r), 8'h01);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_irq", 8'(bus.interrupt_r), 8'h00);
    chk("s6_rst_mask", mask_dbg, 8'hFF);
    chk("s6_rst_pending", bus.pending, 8'h00);
    tick(2);
    reset_n = 1'b1; tick(4);
    chk("s6_no_edge", 8'(bus.interrupt_r), 8'h00);
    chk("s6_no_pend", bus.pending, 8'h00);
    bus.irq_in = 8'h00; tick(1);
    bus.irq_in = 8'h40; tick(2);
    chk("s6_rereq", 8'(bus.interrupt_r), 8'h01);
    chk("s6_vec6", 8'(bus.int_vector), 8'h06);
    ack(); end_irq();

    // Randomized run against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_n = 1'b0; tick(1); reset_n = 1'b1;
      end
      tog = 8'h00;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) tog[b] = 1'b1;
      bus.irq_in     = bus.irq_in ^ tog;
      if ($urandom_range(0, 39) == 0) bus.nmi_in = ~bus.nmi_in;
      bus.CPU_busy   = ($urandom_range(0, 3) == 0);
      bus.INA        = ((cyc / 300) % 2 == 1) ? 1'b0 : ($urandom_range(0, 2) == 0);
      bus.eoi        = ($urandom_range(0, 4) == 0);
      bus.mask_we    = ($urandom_range(0, 15) == 0);
      bus.mask_wdata = 8'($urandom);
      tick(1);
    end

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
